alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Issue-side controller for the 3-bit-opcode ALU.
- Accepts one instruction at a time (opcode + 32-bit operand) over a valid/ready handshake.
- Owns the accumulator register, which it drives onto the ALU's accumulator operand.
- Drives ALU start/opcode/B operand, waits the ALU's registered latency, writes the ALU result back into the accumulator and reports completion.

Parameters:
- WIDTH, 32, datapath and accumulator width.
- MASK_WAIT, 2, cycles the operand is held for opcode 001 (popcount-to-mask), whose ALU result lags one extra register stage.
- ACC_RST, 0, accumulator value on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept.
- instr_op  input  3  ALU opcode.
- instr_load  input  1  1 = load operand directly into accumulator, no ALU issue.
- instr_operand  input  WIDTH  B operand / load value.
- alu_start  output  1  ALU start qualifier.
- alu_opcode  output  3  opcode to ALU.
- alu_acout  output  WIDTH  accumulator value to ALU (always equals acc).
- alu_b  output  WIDTH  B operand to ALU.
- alu_result  input  WIDTH  registered ALU output.
- acc  output  WIDTH  accumulator.
- result_valid  output  1  one-cycle completion pulse.
- result_data  output  WIDTH  accumulator value after completion.
- busy  output  1  not IDLE.
- perf_count  output  16  completed-instruction count (see Optional Feature).

Behaviour:
- Reset (async, any time): FSM to IDLE. acc = ACC_RST. alu_start, alu_opcode, alu_b, result_valid, result_data, perf_count all 0. Any in-flight instruction is discarded with no result_valid.
- instr_ready = 1 only in IDLE and not in reset. Accept = instr_valid & instr_ready on a rising edge (edge E). The op, load flag and operand are registered at accept and held until return to IDLE.
- States:
  - IDLE: on accept with instr_load = 1 → LOAD. With instr_op = 111 → DONE. Otherwise → EXEC, with wait counter = 1, or MASK_WAIT if op = 001.
  - EXEC: alu_start = 1, alu_opcode and alu_b held stable. Counter decrements each edge; at 0 → WB.
  - WB: acc <= alu_result, result_data <= alu_result, result_valid <= 1. → IDLE.
  - LOAD: acc <= operand, result_data <= operand, result_valid <= 1. → IDLE.
  - DONE (op 111 store): acc unchanged, result_data <= acc, result_valid <= 1. → IDLE.
- Latency (E to result_valid high):
  - Ops 000, 010–110: 2 cycles.
  - Op 001: MASK_WAIT + 1 cycles.
  - Load and 111: 1 cycle.
- Back-to-back issue: next accept is possible on the edge after result_valid rises. result_valid is high exactly one cycle.
- alu_start is 0 outside EXEC, so the ALU clears during sequencer reset.
- Arithmetic is performed by the ALU, modulo 2^WIDTH with no flags. The sequencer adds nothing and does not check the result.
- instr_valid may drop without acceptance; no effect. Inputs while busy are ignored.
- Unused ALU outputs outside WB are ignored.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: perf_count increments by 1 (wrapping at 0xFFFF → 0) on every cycle result_valid = 1; cleared by reset.
- Undefined: counter logic removed; perf_count tied to 0. The port remains in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_CLR = 000, OP_MASK = 001, OP_ADD = 010, OP_SUB = 011, OP_OR = 100, OP_AND = 101, OP_XOR = 110, OP_STORE = 111;
  - the FSM state enum (IDLE, EXEC, WB, LOAD, DONE);
  - WIDTH default.
- No sub-module is needed; the single FSM with counter is sufficient. The bench instantiates this block together with the ALU.

Test Plan:
- Load 0x0000_0005, then ADD operand 0x0000_0003 → result_valid 2 cycles after the ADD accept, acc = result_data = 0x0000_0008.
- acc = 0xFFFF_FFFF, ADD 0x1 → acc = 0x0000_0000 (wrap). Then SUB 0x1 → 0xFFFF_FFFF.
- OP_MASK with operand 0x0000_00F0 (4 bits set) → alu_b held for 2 EXEC cycles, acc = 0x0000_000F, latency 3 cycles.
- acc = 0x1234_5678, OP_STORE → result_valid after 1 cycle, result_data = 0x1234_5678, alu_start never asserted.
- Assert rst in the middle of EXEC of an XOR → outputs go to 0 immediately (async). No result_valid. instr_ready = 1 on the first cycle after release. acc = ACC_RST.
- Ten back-to-back instructions with instr_valid held high → instr_ready low while busy, exactly ten result_valid pulses. With SEQ_PERF_CNT_EN, perf_count = 10; without it, perf_count = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode values, sequencer states, default width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_CLR   = 3'b000,
        OP_MASK  = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_OR    = 3'b100,
        OP_AND   = 3'b101,
        OP_XOR   = 3'b110,
        OP_STORE = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WB,
        LOAD,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction issue handshake between an issuer (master) and the ALU op sequencer (slave).
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic             instr_load;
    logic [WIDTH-1:0] instr_operand;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_load,
        output instr_operand,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_load,
        input  instr_operand,
        output instr_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 3-bit-opcode ALU; owns the accumulator and writes ALU results back.
// Build option: define SEQ_PERF_CNT_EN to count completed instructions on perf_count.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int               WIDTH     = ALU_WIDTH,
    parameter int               MASK_WAIT = 2,
    parameter logic [WIDTH-1:0] ACC_RST   = '0
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave instr,
    output logic              alu_start,
    output logic [2:0]        alu_opcode,
    output logic [WIDTH-1:0]  alu_acout,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  acc,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result_data,
    output logic              busy,
    output logic [15:0]       perf_count
);

    localparam int CW = (MASK_WAIT > 1) ? $clog2(MASK_WAIT + 1) : 1;

    seq_state_t    state;
    logic [CW-1:0] cnt;

    assign instr.instr_ready = (state == IDLE) && !rst;
    assign busy              = (state != IDLE);
    assign alu_acout         = acc;

    // alu_opcode/alu_b double as the held copy of the accepted op and operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= ACC_RST;
            alu_start    <= 1'b0;
            alu_opcode   <= '0;
            alu_b        <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr.instr_valid) begin
                        alu_opcode <= instr.instr_op;
                        alu_b      <= instr.instr_operand;
                        if (instr.instr_load) begin
                            state <= LOAD;
                        end else if (instr.instr_op == OP_STORE) begin
                            state <= DONE;
                        end else begin
                            state     <= EXEC;
                            alu_start <= 1'b1;
                            cnt       <= (instr.instr_op == OP_MASK) ? CW'(MASK_WAIT) : CW'(1);
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= WB;
                        alu_start <= 1'b0;
                    end
                end
                WB: begin
                    acc          <= alu_result;
                    result_data  <= alu_result;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                LOAD: begin
                    acc          <= alu_b;
                    result_data  <= alu_b;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                DONE: begin
                    result_data  <= acc;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_count <= '0;
        end else if (result_valid) begin
            perf_count <= perf_count + 16'd1;
        end
    end
`else
    assign perf_count = '0;
`endif

endmodule
